mc_port_mux: RTL
================

Name: mc_port_mux

Overview:
- Merges memory requests from NUM_CORES PHOLD event-processing cores onto one memory-controller port, the port that `dummy_mc` or the real MC serves.
- Routes each MC response back to the core that issued it, using a core-ID tag carried in the upper rtnctl bits.
- Sits between the core array inside `phold` and the MC interface. One request register stage and one response register stage.

Parameters:
- NUM_CORES, 8, number of requesting cores (power of 2, 2..16).
- MC_RTNCTL_WIDTH, 32, rtnctl width on the MC side.
- CORE_ID_W, $clog2(NUM_CORES), tag width placed in rtnctl[MC_RTNCTL_WIDTH-1 -: CORE_ID_W].
- CORE_RTNCTL_W, MC_RTNCTL_WIDTH-CORE_ID_W, rtnctl width on the core side.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_rq_vld  in  NUM_CORES  per-core request valid
- core_rq_cmd  in  3*NUM_CORES  packed cmd; core i occupies [3i+:3]
- core_rq_scmd  in  4*NUM_CORES  packed sub-command
- core_rq_vadr  in  48*NUM_CORES  packed virtual address
- core_rq_size  in  2*NUM_CORES  packed size
- core_rq_rtnctl  in  CORE_RTNCTL_W*NUM_CORES  packed core rtnctl
- core_rq_data  in  64*NUM_CORES  packed write data
- core_rq_stall  out  NUM_CORES  per-core stall; a request transfers when vld && !stall
- mc_rq_vld / mc_rq_cmd / mc_rq_scmd / mc_rq_vadr / mc_rq_size / mc_rq_rtnctl / mc_rq_data  out  1/3/4/48/2/MC_RTNCTL_WIDTH/64  MC request
- mc_rq_flush  out  1  tied 0
- mc_rq_stall  in  1  MC backpressure
- mc_rs_vld / mc_rs_cmd / mc_rs_scmd / mc_rs_rtnctl / mc_rs_data  in  1/3/4/MC_RTNCTL_WIDTH/64  MC response
- mc_rs_stall  out  1  response backpressure to the MC
- core_rs_vld  out  NUM_CORES  one-hot response valid
- core_rs_cmd / core_rs_scmd / core_rs_rtnctl / core_rs_data  out  3/4/CORE_RTNCTL_W/64  response fields, broadcast to all cores
- core_rs_stall  in  NUM_CORES  per-core response stall

Behaviour:
- Reset: every output is 0, except that core_rq_stall is all-ones while reset is high. rr_ptr=0. Both register stages become empty. Any in-flight request or response is dropped.
- Request stage "free" condition: rq_free = !mc_rq_vld || !mc_rq_stall.
- Arbitration:
  - Round-robin over core_rq_vld, starting the search at rr_ptr.
  - When rq_free and at least one core requests, winner w is granted.
  - Grant actions: core_rq_stall[w]=0; the output register loads w's fields; mc_rq_rtnctl={w[CORE_ID_W-1:0], core_rq_rtnctl_w}; rr_ptr <= w+1, wrapping modulo NUM_CORES.
- Stall outputs: all non-granted cores see stall=1. If !rq_free, every core sees stall=1. core_rq_stall is combinational from core_rq_vld, rr_ptr, mc_rq_vld and mc_rq_stall.
- mc_rq_vld: registered. While mc_rq_stall=1 it holds its value and all fields stay stable. It drops to 0 when the register is free and no core requests.
- Request latency: 1 cycle from the core transfer to mc_rq_vld.
- Back-to-back: with the MC not stalling, one grant per cycle is sustained at full throughput.
- Response path:
  - The MC response is captured into a 1-entry register when rs_free = !rs_vld_q || !core_rs_stall[dst_q].
  - dst = mc_rs_rtnctl tag bits; core_rs_rtnctl = the low CORE_RTNCTL_W bits.
  - core_rs_vld = rs_vld_q ? (1<<dst_q) : 0.
  - mc_rs_stall = !rs_free. Combinational; a response transfers when mc_rs_vld && !mc_rs_stall.
- Response latency: 1 cycle.
- Simultaneous events: a request grant and a response transfer in the same cycle are independent.
- A core may hold vld while stalled. Its fields must stay stable; the mux does not check this.

Optional Feature:
- Macro: MC_PORT_MUX_STATS_EN.
- When defined, adds three outputs, all 64-bit counters cleared by reset and saturating at all-ones:
  - stat_grants: increments on each request grant.
  - stat_mc_stall_cycles: increments on each cycle with mc_rq_vld && mc_rq_stall.
  - stat_conflicts: increments on each cycle with more than one core_rq_vld bit set while rq_free.
- When undefined, these ports and counters do not exist, and the block's behaviour is otherwise identical.

Decomposition:
- Shared package `pdes_mc_pkg`:
  - MC command encodings: RD=1, WR=2.
  - Field widths: 48 (vadr), 64 (data), 3 (cmd), 4 (scmd), 2 (size).
  - A core-ID tag-position function.
- Sub-module `rr_arbiter`: parameterised NUM_CORES round-robin arbiter. Inputs: req vector, rr_ptr, enable. Outputs: one-hot grant and grant index.
- The rest stays in `mc_port_mux`.

Test Plan:
- Reset: assert reset for 2 cycles while core 3 requests. Required: mc_rq_vld=0, core_rs_vld=0, core_rq_stall=8'hFF. After release, core 3 is granted on the first cycle.
- Round-robin: all 8 cores request continuously, MC never stalls. Required: mc_rq_rtnctl tags arrive 0,1,2,...,7,0, one per cycle. Each core gets 1 grant per 8 cycles.
- MC backpressure: mc_rq_stall=1 for 5 cycles during a core 2 write to vadr 48'h1000. Required: mc_rq_vld and all fields hold for 5 cycles, all core_rq_stall=1, and exactly one MC write is issued.
- Response routing: inject mc_rs_vld with rtnctl={3'd5, 29'h0ABC}. Required: the next cycle shows core_rs_vld=8'b0010_0000 and core_rs_rtnctl=29'h0ABC.
- Response backpressure: hold core_rs_stall[5]=1 while two responses for core 5 arrive. Required: mc_rs_stall=1 after the first is captured, the second waits at the MC, and both are delivered in order once the stall is released.
- Stats (with MC_PORT_MUX_STATS_EN defined): run the round-robin scenario for 100 grants and apply 5 stall cycles. Required: stat_grants=100 and stat_mc_stall_cycles=5.

Source files
------------

// File: rtl/pdes_mc_pkg.sv
// Shared memory-controller definitions for the PHOLD core array:
// command encodings, request/response field widths, grouped field structs
// and the position of the core-ID tag inside rtnctl.
package pdes_mc_pkg;

    localparam int MC_CMD_W  = 3;
    localparam int MC_SCMD_W = 4;
    localparam int MC_VADR_W = 48;
    localparam int MC_DATA_W = 64;
    localparam int MC_SIZE_W = 2;

    typedef enum logic [MC_CMD_W-1:0] {
        MC_CMD_IDLE = 3'd0,
        MC_CMD_RD   = 3'd1,
        MC_CMD_WR   = 3'd2
    } mc_cmd_e;

    // Request fields that travel unchanged from a core to the MC.
    typedef struct packed {
        logic [MC_CMD_W-1:0]  cmd;
        logic [MC_SCMD_W-1:0] scmd;
        logic [MC_VADR_W-1:0] vadr;
        logic [MC_SIZE_W-1:0] size;
        logic [MC_DATA_W-1:0] data;
    } mc_rq_fields_t;

    // Response fields that travel unchanged from the MC to a core.
    typedef struct packed {
        logic [MC_CMD_W-1:0]  cmd;
        logic [MC_SCMD_W-1:0] scmd;
        logic [MC_DATA_W-1:0] data;
    } mc_rs_fields_t;

    // The core-ID tag occupies the top id_w bits of an rtnctl_w-bit rtnctl.
    function automatic int core_tag_lsb(input int rtnctl_w, input int id_w);
        return rtnctl_w - id_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found when searching
// upward from ptr, wrapping modulo NUM_CORES (NUM_CORES is a power of 2,
// so the wrap is the natural overflow of the index width).
module rr_arbiter #(
    parameter int NUM_CORES = 8,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 enable,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_vld
);

    logic [IDX_W-1:0] cand;

    // Priority search starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = ptr + IDX_W'(i);
            if (enable && !grant_vld && req[cand]) begin
                grant_vld       = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mc_port_mux.sv
// Merges requests from NUM_CORES PHOLD cores onto a single MC port and routes
// MC responses back to the issuing core via a core-ID tag in the top rtnctl
// bits. One request register stage, one response register stage.
// Optional build macro MC_PORT_MUX_STATS_EN adds saturating 64-bit counters
// for grants, MC stall cycles and multi-requester cycles.
module mc_port_mux
    import pdes_mc_pkg::*;
#(
    parameter int NUM_CORES       = 8,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int CORE_ID_W       = $clog2(NUM_CORES),
    parameter int CORE_RTNCTL_W   = MC_RTNCTL_WIDTH - CORE_ID_W
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_CORES-1:0]             core_rq_vld,
    input  logic [MC_CMD_W*NUM_CORES-1:0]    core_rq_cmd,
    input  logic [MC_SCMD_W*NUM_CORES-1:0]   core_rq_scmd,
    input  logic [MC_VADR_W*NUM_CORES-1:0]   core_rq_vadr,
    input  logic [MC_SIZE_W*NUM_CORES-1:0]   core_rq_size,
    input  logic [CORE_RTNCTL_W*NUM_CORES-1:0] core_rq_rtnctl,
    input  logic [MC_DATA_W*NUM_CORES-1:0]   core_rq_data,
    output logic [NUM_CORES-1:0]             core_rq_stall,

    output logic                             mc_rq_vld,
    output logic [MC_CMD_W-1:0]              mc_rq_cmd,
    output logic [MC_SCMD_W-1:0]             mc_rq_scmd,
    output logic [MC_VADR_W-1:0]             mc_rq_vadr,
    output logic [MC_SIZE_W-1:0]             mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0]       mc_rq_rtnctl,
    output logic [MC_DATA_W-1:0]             mc_rq_data,
    output logic                             mc_rq_flush,
    input  logic                             mc_rq_stall,

    input  logic                             mc_rs_vld,
    input  logic [MC_CMD_W-1:0]              mc_rs_cmd,
    input  logic [MC_SCMD_W-1:0]             mc_rs_scmd,
    input  logic [MC_RTNCTL_WIDTH-1:0]       mc_rs_rtnctl,
    input  logic [MC_DATA_W-1:0]             mc_rs_data,
    output logic                             mc_rs_stall,

    output logic [NUM_CORES-1:0]             core_rs_vld,
    output logic [MC_CMD_W-1:0]              core_rs_cmd,
    output logic [MC_SCMD_W-1:0]             core_rs_scmd,
    output logic [CORE_RTNCTL_W-1:0]         core_rs_rtnctl,
    output logic [MC_DATA_W-1:0]             core_rs_data,
`ifdef MC_PORT_MUX_STATS_EN
    output logic [63:0]                      stat_grants,
    output logic [63:0]                      stat_mc_stall_cycles,
    output logic [63:0]                      stat_conflicts,
`endif
    input  logic [NUM_CORES-1:0]             core_rs_stall
);

    localparam int TAG_LSB = core_tag_lsb(MC_RTNCTL_WIDTH, CORE_ID_W);

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic                     rq_free;
    logic [NUM_CORES-1:0]     grant;
    logic [CORE_ID_W-1:0]     grant_idx;
    logic                     grant_vld;
    logic [CORE_ID_W-1:0]     rr_ptr;
    mc_rq_fields_t            win_fields;
    logic [CORE_RTNCTL_W-1:0] win_rtnctl;
    mc_rq_fields_t            mc_rq_q;

    // The output register can accept a new entry when empty or being drained.
    assign rq_free = !mc_rq_vld || !mc_rq_stall;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (CORE_ID_W)
    ) u_rr_arbiter (
        .req       (core_rq_vld),
        .ptr       (rr_ptr),
        .enable    (rq_free),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Only the granted core sees stall low; everyone is held off during reset.
    assign core_rq_stall = reset ? '1 : ~grant;

    // Pick the winning core's slice out of each packed request bus.
    always_comb begin
        win_fields.cmd  = core_rq_cmd [MC_CMD_W*grant_idx  +: MC_CMD_W];
        win_fields.scmd = core_rq_scmd[MC_SCMD_W*grant_idx +: MC_SCMD_W];
        win_fields.vadr = core_rq_vadr[MC_VADR_W*grant_idx +: MC_VADR_W];
        win_fields.size = core_rq_size[MC_SIZE_W*grant_idx +: MC_SIZE_W];
        win_fields.data = core_rq_data[MC_DATA_W*grant_idx +: MC_DATA_W];
        win_rtnctl      = core_rq_rtnctl[CORE_RTNCTL_W*grant_idx +: CORE_RTNCTL_W];
    end

    // Request register: loads the winner when free, holds while the MC stalls.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the payload is reset as well as the valid because the
            // outputs are required to read zero out of reset.
            mc_rq_vld    <= 1'b0;
            mc_rq_q      <= '0;
            mc_rq_rtnctl <= '0;
            rr_ptr       <= '0;
        end else if (rq_free) begin
            mc_rq_vld <= grant_vld;
            if (grant_vld) begin
                mc_rq_q      <= win_fields;
                // Tag lands in rtnctl[TAG_LSB +: CORE_ID_W].
                mc_rq_rtnctl <= {grant_idx, win_rtnctl};
                rr_ptr       <= grant_idx + CORE_ID_W'(1);
            end
        end
    end

    assign mc_rq_cmd   = mc_rq_q.cmd;
    assign mc_rq_scmd  = mc_rq_q.scmd;
    assign mc_rq_vadr  = mc_rq_q.vadr;
    assign mc_rq_size  = mc_rq_q.size;
    assign mc_rq_data  = mc_rq_q.data;
    assign mc_rq_flush = 1'b0;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic                     rs_vld_q;
    logic [CORE_ID_W-1:0]     rs_dst_q;
    logic [CORE_RTNCTL_W-1:0] rs_rtnctl_q;
    mc_rs_fields_t            rs_q;
    logic                     rs_free;

    // The response register frees up once its destination core accepts it.
    assign rs_free     = !rs_vld_q || !core_rs_stall[rs_dst_q];
    assign mc_rs_stall = !reset && !rs_free;

    // Response register: captures the MC response and decodes its destination.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_vld_q    <= 1'b0;
            rs_dst_q    <= '0;
            rs_rtnctl_q <= '0;
            rs_q        <= '0;
        end else if (rs_free) begin
            rs_vld_q <= mc_rs_vld;
            if (mc_rs_vld) begin
                rs_dst_q    <= mc_rs_rtnctl[TAG_LSB +: CORE_ID_W];
                rs_rtnctl_q <= mc_rs_rtnctl[CORE_RTNCTL_W-1:0];
                rs_q        <= '{cmd: mc_rs_cmd, scmd: mc_rs_scmd, data: mc_rs_data};
            end
        end
    end

    // One-hot valid toward the destination core; payload is broadcast.
    always_comb begin
        core_rs_vld = '0;
        if (rs_vld_q) begin
            core_rs_vld[rs_dst_q] = 1'b1;
        end
    end

    assign core_rs_cmd    = rs_q.cmd;
    assign core_rs_scmd   = rs_q.scmd;
    assign core_rs_data   = rs_q.data;
    assign core_rs_rtnctl = rs_rtnctl_q;

`ifdef MC_PORT_MUX_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic multi_req;

    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    // More than one requester: clearing the lowest set bit leaves something.
    assign multi_req = (core_rq_vld & (core_rq_vld - NUM_CORES'(1))) != '0;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants          <= '0;
            stat_mc_stall_cycles <= '0;
            stat_conflicts       <= '0;
        end else begin
            if (grant_vld) begin
                stat_grants <= sat_inc(stat_grants);
            end
            if (mc_rq_vld && mc_rq_stall) begin
                stat_mc_stall_cycles <= sat_inc(stat_mc_stall_cycles);
            end
            if (multi_req && rq_free) begin
                stat_conflicts <= sat_inc(stat_conflicts);
            end
        end
    end
`endif

endmodule
